// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART TX packet scheduler.
package uart_tx_scheduler_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2
  } state_e;

  // Packet byte positions: {SYNC, channel id, data, checksum}.
  localparam logic [1:0] IdxSync = 2'd0;
  localparam logic [1:0] IdxId   = 2'd1;
  localparam logic [1:0] IdxData = 2'd2;
  localparam logic [1:0] IdxChk  = 2'd3;

  localparam logic [7:0] DefaultSyncByte = 8'hAA;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from last+1, wrapping.
module uart_tx_scheduler_rr_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned ID_W = 3
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic [N_CH-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            valid
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  int            c;
  logic [CW-1:0] sel;

  // Walk candidates from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    c       = 0;
    sel     = '0;
    for (int i = int'(N_CH); i >= 1; i--) begin
      c   = (int'(last) + i) % int'(N_CH);
      sel = CW'(c);
      if (req[sel]) begin
        gnt     = N_CH'(1) << sel;
        gnt_idx = ID_W'(c);
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX channel among N_CH sensor channels, sending 4-byte packets
// {SYNC, id, data, checksum} one byte per tx_start/tx_done handshake.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter logic [7:0]  SYNC_BYTE = DefaultSyncByte,
  parameter int unsigned ID_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic [8*N_CH-1:0] data_in,
  output logic [N_CH-1:0]   ack,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy
);

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      sample_q, sample_d;

  logic [N_CH-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_valid;
  logic [7:0]      gnt_data;
  logic [7:0]      id_byte;
  logic [7:0]      pkt_byte;

  uart_tx_scheduler_rr_arbiter #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_arb (
    .req     (req),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .valid   (gnt_valid)
  );

  assign gnt_data = 8'(data_in >> {gnt_idx, 3'b000});

  // Next-state: grant and latch in IDLE, pulse start in SEND, wait for done in WAIT.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    id_d     = id_q;
    sample_d = sample_q;
    ack      = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          ack      = gnt;
          sample_d = gnt_data;
          id_d     = gnt_idx;
          idx_d    = IdxSync;
          last_d   = gnt_idx;
          state_d  = StSend;
        end
      end
      StSend: state_d = StWait;
      StWait: begin
        if (tx_done) begin
          if (idx_q == IdxChk) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A grant made while reset is asserted would be lost, so never acknowledge it.
    if (rst) ack = '0;
  end

  // Packet byte mux; tx_data reads zero when idle.
  always_comb begin
    id_byte = 8'(id_q);
    unique case (idx_q)
      IdxSync: pkt_byte = SYNC_BYTE;
      IdxId:   pkt_byte = id_byte;
      IdxData: pkt_byte = sample_q;
      default: pkt_byte = SYNC_BYTE ^ id_byte ^ sample_q;
    endcase
    busy     = (state_q != StIdle);
    tx_start = (state_q == StSend);
    tx_data  = busy ? pkt_byte : 8'h00;
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= IdxSync;
      last_q   <= ID_W'(N_CH - 1);
      id_q     <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      id_q     <= id_d;
      sample_q <= sample_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a round-robin / packet reference model.
module tb_uart_tx_scheduler;

  localparam int N = 4;
  localparam logic [7:0] SYNC = 8'hAA;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data_in;
  logic [N-1:0]   ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic           busy;

  int n_cmp;
  int n_fail;
  int model_last;

  uart_tx_scheduler #(
    .N_CH      (N),
    .SYNC_BYTE (SYNC),
    .ID_W      (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Round-robin rule: first requester strictly after 'last', wrapping.
  function automatic int rr_model(input logic [N-1:0] r, input int last);
    int k;
    for (int j = 1; j <= N; j++) begin
      k = (last + j) % N;
      if (((r >> k) & 4'b0001) != 4'b0000) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pkt_model(input int ch, input logic [7:0] d);
    logic [7:0] id;
    id = 8'(ch);
    return {SYNC, id, d, SYNC ^ id ^ d};
  endfunction

  function automatic logic [7:0] chan_data(input logic [8*N-1:0] v, input int ch);
    return 8'(v >> (8 * ch));
  endfunction

  function automatic logic [8*N-1:0] set_chan(input logic [8*N-1:0] v, input int ch,
                                              input logic [7:0] d);
    logic [8*N-1:0] m;
    m = {{(8*N-8){1'b0}}, 8'hFF} << (8 * ch);
    return (v & ~m) | ({{(8*N-8){1'b0}}, d} << (8 * ch));
  endfunction

  // Acts as the transmitter for one packet: waits for an ack, then answers each
  // tx_start with tx_done after dly cycles, recording bytes and protocol hazards.
  task automatic run_packet(input int dly, input bit reraise, input bit stop, input bit spurious,
                            input logic [8*N-1:0] data_after, input int abort_b,
                            output int ch, output logic [31:0] pkt, output int starts,
                            output bit timing_ok, output bit stable_ok, output bit onehot);
    logic [7:0] held;
    bit found;
    int w;
    int nd;
    ch = -1; pkt = '0; starts = 0; timing_ok = 1'b1; stable_ok = 1'b1; onehot = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (ack !== '0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      timing_ok = 1'b0;
      return;
    end
    onehot = ($countones(ack) == 1) && (busy === 1'b0);
    for (int i = 0; i < N; i++) if (((ack >> i) & 4'b0001) != 4'b0000) ch = i;
    @(negedge clk);
    req = req & ~(4'b0001 << ch);
    data_in = data_after;
    for (int b = 0; b < 4; b++) begin
      w = 0;
      while (tx_start !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w != 0) timing_ok = 1'b0;
      if (w == 50) return;
      starts++;
      held = tx_data;
      pkt[8*(3-b) +: 8] = held;
      if (b == abort_b) begin
        @(negedge clk);
        return;
      end
      nd = dly;
      if (spurious && b == 0) begin
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        nd = dly - 1;
        if (tx_start !== 1'b0) begin starts++; stable_ok = 1'b0; end
        if (tx_data !== held) stable_ok = 1'b0;
      end
      for (int d = 0; d < nd; d++) begin
        @(negedge clk);
        if (b == 0 && d == 0 && reraise) req = req | (4'b0001 << ch);
        if (tx_start !== 1'b0) begin starts++; stable_ok = 1'b0; end
        if (tx_data !== held) stable_ok = 1'b0;
        if (ack !== '0) onehot = 1'b0;
      end
      if (b == 3 && stop) req = '0;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; tx_done = 1'b0; data_in = {$urandom};
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; req = '0; model_last = N - 1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int ch; logic [31:0] pkt; int st; bit tok, sok, oh; int extra;
    data_in = set_chan({$urandom}, 2, 8'h3C);
    req = 4'b0100;
    run_packet(5, 1'b0, 1'b1, 1'b0, data_in, -1, ch, pkt, st, tok, sok, oh);
    n_cmp++; if (ch !== 2) begin n_fail++; $display("FAIL single_ch: got %0d want 2", ch); end
    n_cmp++; if (pkt !== pkt_model(2, 8'h3C)) begin n_fail++; $display("FAIL single_pkt: got %h want %h", pkt, pkt_model(2, 8'h3C)); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b want 0", busy); end
    n_cmp++; if ({tok, sok, oh} !== 3'b111) begin n_fail++; $display("FAIL single_proto: got %b want 111", {tok, sok, oh}); end
    extra = 0;
    repeat (4) begin
      #1; if (ack !== '0 || tx_start !== 1'b0) extra++;
      @(negedge clk);
    end
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL single_no_reack: got %0d want 0", extra); end
    model_last = 2;
  endtask

  task automatic test_contention();
    int ch; logic [31:0] pkt; int st; bit tok, sok, oh; int exp; logic [31:0] ep;
    test_reset();
    data_in = {$urandom};
    req = '1;
    for (int p = 0; p < 5; p++) begin
      exp = rr_model(req, model_last);
      ep = pkt_model(exp, chan_data(data_in, exp));
      run_packet(2 + p % 3, p < 4, p == 4, 1'b0, data_in, -1, ch, pkt, st, tok, sok, oh);
      n_cmp++; if (ch !== exp) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", p, ch, exp); end
      n_cmp++; if (pkt !== ep) begin n_fail++; $display("FAIL rr_pkt[%0d]: got %h want %h", p, pkt, ep); end
      n_cmp++; if (st !== 4) begin n_fail++; $display("FAIL rr_starts[%0d]: got %0d want 4", p, st); end
      n_cmp++; if ({tok, sok, oh} !== 3'b111) begin n_fail++; $display("FAIL rr_proto[%0d]: got %b want 111", p, {tok, sok, oh}); end
      model_last = exp;
    end
    #1;
    n_cmp++; if (ack !== '0) begin n_fail++; $display("FAIL rr_drained: got %b want 0", ack); end
    @(negedge clk);
  endtask

  task automatic test_spurious_done();
    int ch; logic [31:0] pkt; int st; bit tok, sok, oh;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    n_cmp++; if ({busy, tx_start} !== 2'b00) begin n_fail++; $display("FAIL spur_idle: got %b want 00", {busy, tx_start}); end
    data_in = set_chan({$urandom}, 0, 8'h11);
    req = 4'b0001;
    run_packet(3, 1'b0, 1'b1, 1'b1, data_in, -1, ch, pkt, st, tok, sok, oh);
    n_cmp++; if (ch !== 0) begin n_fail++; $display("FAIL spur_ch: got %0d want 0", ch); end
    n_cmp++; if (pkt !== pkt_model(0, 8'h11)) begin n_fail++; $display("FAIL spur_pkt: got %h want %h", pkt, pkt_model(0, 8'h11)); end
    n_cmp++; if (st !== 4) begin n_fail++; $display("FAIL spur_starts: got %0d want 4", st); end
    n_cmp++; if ({tok, sok} !== 2'b11) begin n_fail++; $display("FAIL spur_proto: got %b want 11", {tok, sok}); end
    model_last = 0;
  endtask

  task automatic test_data_hold();
    int ch; logic [31:0] pkt; int st; bit tok, sok, oh;
    data_in = set_chan({$urandom}, 1, 8'h55);
    req = 4'b0010;
    run_packet(4, 1'b0, 1'b1, 1'b0, set_chan(data_in, 1, 8'hFF), -1, ch, pkt, st, tok, sok, oh);
    n_cmp++; if (ch !== 1) begin n_fail++; $display("FAIL hold_ch: got %0d want 1", ch); end
    n_cmp++; if (pkt !== pkt_model(1, 8'h55)) begin n_fail++; $display("FAIL hold_pkt: got %h want %h", pkt, pkt_model(1, 8'h55)); end
    n_cmp++; if (sok !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got %b want 1", sok); end
    model_last = 1;
  endtask

  task automatic test_reset_mid_packet();
    int ch; logic [31:0] pkt; int st; bit tok, sok, oh; logic [7:0] d;
    data_in = set_chan({$urandom}, 2, 8'h77);
    req = 4'b0100;
    run_packet(3, 1'b0, 1'b0, 1'b0, data_in, 2, ch, pkt, st, tok, sok, oh);
    n_cmp++; if (pkt[31:8] !== pkt_model(2, 8'h77) >> 8) begin n_fail++; $display("FAIL abort_prefix: got %h want %h", pkt[31:8], pkt_model(2, 8'h77) >> 8); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({tx_start, busy, tx_data, ack} !== '0) begin n_fail++; $display("FAIL abort_state: start=%b busy=%b data=%h ack=%b want all 0", tx_start, busy, tx_data, ack); end
    rst = 1'b0;
    model_last = N - 1;
    @(negedge clk);
    n_cmp++; if ({tx_start, busy, ack} !== '0) begin n_fail++; $display("FAIL abort_quiet: got %b want 0", {tx_start, busy, ack}); end
    d = 8'($urandom);
    data_in = set_chan({$urandom}, 0, d);
    req = 4'b0001;
    run_packet(2, 1'b0, 1'b1, 1'b0, data_in, -1, ch, pkt, st, tok, sok, oh);
    n_cmp++; if (ch !== 0) begin n_fail++; $display("FAIL abort_regrant: got %0d want 0", ch); end
    n_cmp++; if (pkt !== pkt_model(0, d)) begin n_fail++; $display("FAIL abort_fresh_pkt: got %h want %h", pkt, pkt_model(0, d)); end
    model_last = 0;
  endtask

  task automatic test_wraparound();
    int ch; logic [31:0] pkt; int st; bit tok, sok, oh; int exp;
    data_in = {$urandom};
    req = 4'b1000;
    run_packet(1, 1'b0, 1'b1, 1'b0, data_in, -1, ch, pkt, st, tok, sok, oh);
    n_cmp++; if (ch !== 3) begin n_fail++; $display("FAIL wrap_setup: got %0d want 3", ch); end
    model_last = 3;
    req = 4'b1001;
    for (int p = 0; p < 2; p++) begin
      exp = rr_model(req, model_last);
      run_packet(2, 1'b0, p == 1, 1'b0, data_in, -1, ch, pkt, st, tok, sok, oh);
      n_cmp++; if (ch !== exp) begin n_fail++; $display("FAIL wrap_order[%0d]: got %0d want %0d", p, ch, exp); end
      model_last = exp;
    end
  endtask

  task automatic test_random();
    int ch; logic [31:0] pkt; int st; bit tok, sok, oh; int exp; int dly; logic [31:0] ep;
    logic [N-1:0] r;
    for (int p = 0; p < 20; p++) begin
      r = 4'($urandom_range(1, 15));
      data_in = {$urandom};
      req = r;
      exp = rr_model(r, model_last);
      ep = pkt_model(exp, chan_data(data_in, exp));
      dly = $urandom_range(1, 6);
      run_packet(dly, 1'b0, 1'b1, (dly >= 2) && ($urandom_range(0, 1) == 1), {$urandom}, -1,
                 ch, pkt, st, tok, sok, oh);
      n_cmp++; if (ch !== exp) begin n_fail++; $display("FAIL rand_ch[%0d]: req=%b got %0d want %0d", p, r, ch, exp); end
      n_cmp++; if (pkt !== ep) begin n_fail++; $display("FAIL rand_pkt[%0d]: got %h want %h", p, pkt, ep); end
      n_cmp++; if ({st == 4, tok, sok, oh, busy} !== 5'b11110) begin n_fail++; $display("FAIL rand_proto[%0d]: starts=%0d flags=%b busy=%b want 4/111/0", p, st, {tok, sok, oh}, busy); end
      model_last = exp;
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; model_last = N - 1;
    rst = 1'b1; req = '0; tx_done = 1'b0; data_in = '0;
    test_reset();
    test_single();
    test_contention();
    test_spurious_done();
    test_data_hold();
    test_reset_mid_packet();
    test_wraparound();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
